mor1kx_wb_sequencer_espresso: RTL and testbench

Writeback sequencer for the espresso pipeline, directly upstream of the espresso register file. Merges single-cycle ALU results and multi-cycle data-bus load returns into one registered write port (rf_we_o, rfd_adr_o, result_o) that drives the register file write strobe, destination address and write data. Owns load-data lane extraction and sign/zero extension, stalls the pipeline while a load is outstanding, and serialises same-cycle ALU/load write collisions through a one-entry holding buffer.

---
 rtl/mor1kx_wb_sequencer_espresso_if.sv | 36 +++
 rtl/mor1kx_wb_sequencer_espresso.sv | 154 +++++++++++++++
 tb/tb_mor1kx_wb_sequencer_espresso.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_wb_sequencer_espresso_if.sv
// Writeback sequencer bus bundle: ALU/LSU/data-bus inputs and the register-file write port.
interface mor1kx_wb_sequencer_espresso_if #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
);
    logic                            alu_valid_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] alu_rfd_i;
    logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i;
    logic                            lsu_load_start_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_rfd_i;
    logic [1:0]                      lsu_size_i;
    logic                            lsu_signed_i;
    logic [1:0]                      lsu_adr_lo_i;
    logic                            dbus_ack_i;
    logic                            dbus_err_i;
    logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i;
    logic                            rf_we_o;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_o;
    logic [OPTION_OPERAND_WIDTH-1:0] result_o;
    logic                            stall_o;
    logic                            except_o;

    modport master (
        output alu_valid_i, alu_rfd_i, alu_result_i,
        output lsu_load_start_i, lsu_rfd_i, lsu_size_i, lsu_signed_i, lsu_adr_lo_i,
        output dbus_ack_i, dbus_err_i, dbus_dat_i,
        input  rf_we_o, rfd_adr_o, result_o, stall_o, except_o
    );

    modport slave (
        input  alu_valid_i, alu_rfd_i, alu_result_i,
        input  lsu_load_start_i, lsu_rfd_i, lsu_size_i, lsu_signed_i, lsu_adr_lo_i,
        input  dbus_ack_i, dbus_err_i, dbus_dat_i,
        output rf_we_o, rfd_adr_o, result_o, stall_o, except_o
    );
endinterface

// File: rtl/mor1kx_wb_sequencer_espresso.sv
// Espresso writeback sequencer: merges ALU results and load returns into one registered RF write port.
// Optional MOR1KX_WB_R0_GUARD_EN suppresses every write addressed to register 0.
module mor1kx_wb_sequencer_espresso #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input logic                           clk,
    input logic                           rst,
    mor1kx_wb_sequencer_espresso_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [OPTION_RF_ADDR_WIDTH-1:0] ld_rfd;
    logic [1:0]                      ld_size;
    logic                            ld_signed;
    logic [1:0]                      ld_adr_lo;
    logic [OPTION_RF_ADDR_WIDTH-1:0] hold_rfd;
    logic [OPTION_OPERAND_WIDTH-1:0] hold_result;

    logic                            rf_we;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr;
    logic [OPTION_OPERAND_WIDTH-1:0] result;
    logic                            except_q;

    logic                            wr_en;
    logic                            wr_commit;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wr_adr;
    logic [OPTION_OPERAND_WIDTH-1:0] wr_dat;
    logic                            ld_latch;
    logic                            hold_load;
    logic                            except_nxt;

    logic [7:0]                      lane_b;
    logic [15:0]                     lane_h;
    logic [OPTION_OPERAND_WIDTH-1:0] ld_data;

    // Big-endian lane select: lowest address holds the most significant byte.
    always_comb begin
        lane_b  = '0;
        ld_data = bus.dbus_dat_i;
        unique case (ld_adr_lo)
            2'd0: lane_b = bus.dbus_dat_i[31:24];
            2'd1: lane_b = bus.dbus_dat_i[23:16];
            2'd2: lane_b = bus.dbus_dat_i[15:8];
            2'd3: lane_b = bus.dbus_dat_i[7:0];
            default: lane_b = '0;
        endcase
        lane_h = ld_adr_lo[1] ? bus.dbus_dat_i[15:0] : bus.dbus_dat_i[31:16];
        unique case (ld_size)
            2'b00:   ld_data = {{(OPTION_OPERAND_WIDTH-8){ld_signed & lane_b[7]}}, lane_b};
            2'b01:   ld_data = {{(OPTION_OPERAND_WIDTH-16){ld_signed & lane_h[15]}}, lane_h};
            default: ld_data = bus.dbus_dat_i;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        wr_adr     = bus.alu_rfd_i;
        wr_dat     = bus.alu_result_i;
        ld_latch   = 1'b0;
        hold_load  = 1'b0;
        except_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                wr_en = bus.alu_valid_i;
                if (bus.lsu_load_start_i) begin
                    ld_latch  = 1'b1;
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (bus.dbus_err_i) begin
                    except_nxt = 1'b1;
                    wr_en      = bus.alu_valid_i;
                    state_nxt  = IDLE;
                end else if (bus.dbus_ack_i) begin
                    wr_en  = 1'b1;
                    wr_adr = ld_rfd;
                    wr_dat = ld_data;
                    if (bus.alu_valid_i) begin
                        hold_load = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wr_en = bus.alu_valid_i;
                end
            end
            HOLD: begin
                wr_en     = 1'b1;
                wr_adr    = hold_rfd;
                wr_dat    = hold_result;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MOR1KX_WB_R0_GUARD_EN
    assign wr_commit = wr_en & (wr_adr != '0);
`else
    assign wr_commit = wr_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ld_rfd      <= '0;
            ld_size     <= '0;
            ld_signed   <= 1'b0;
            ld_adr_lo   <= '0;
            hold_rfd    <= '0;
            hold_result <= '0;
            rf_we       <= 1'b0;
            rfd_adr     <= '0;
            result      <= '0;
            except_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rf_we    <= wr_commit;
            except_q <= except_nxt;
            if (wr_commit) begin
                rfd_adr <= wr_adr;
                result  <= wr_dat;
            end
            if (ld_latch) begin
                ld_rfd    <= bus.lsu_rfd_i;
                ld_size   <= bus.lsu_size_i;
                ld_signed <= bus.lsu_signed_i;
                ld_adr_lo <= bus.lsu_adr_lo_i;
            end
            if (hold_load) begin
                hold_rfd    <= bus.alu_rfd_i;
                hold_result <= bus.alu_result_i;
            end
        end
    end

    assign bus.rf_we_o   = rf_we;
    assign bus.rfd_adr_o = rfd_adr;
    assign bus.result_o  = result;
    assign bus.except_o  = except_q;
    assign bus.stall_o   = (state == LOAD_WAIT) | (state == HOLD);

endmodule

// File: tb/tb_mor1kx_wb_sequencer_espresso.sv
// Bench for the espresso writeback sequencer: queue-based reference model, directed and random stimulus.
module tb_mor1kx_wb_sequencer_espresso;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mor1kx_wb_sequencer_espresso_if #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5)) bus ();

    mor1kx_wb_sequencer_espresso #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_RF_ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: writes waiting for the port, plus the outstanding load descriptor.
    wr_t         q[$];
    bit          load_out;
    logic [4:0]  m_rfd;
    logic [1:0]  m_size;
    bit          m_signed;
    logic [1:0]  m_adr;
    logic        e_we, e_stall, e_exc;
    logic [4:0]  e_adr;
    logic [31:0] e_dat;

    function automatic logic [31:0] extract(logic [31:0] d, logic [1:0] sz, bit sg, logic [1:0] a);
        int unsigned v;
        int unsigned bits;
        if (sz == 2'b00) begin
            v    = (d >> (8 * (3 - int'(a)))) & 32'hFF;
            bits = 8;
        end else if (sz == 2'b01) begin
            v    = (d >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
            bits = 16;
        end else begin
            return d;
        end
        if (sg && v[bits-1]) v = v | ~((32'd1 << bits) - 32'd1);
        return v;
    endfunction

    task automatic model_step();
        bit  deferred;
        bit  guard;
        wr_t w;
`ifdef MOR1KX_WB_R0_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        if (rst) begin
            q.delete();
            load_out = 1'b0;
            e_we = 1'b0; e_adr = '0; e_dat = '0; e_stall = 1'b0; e_exc = 1'b0;
            return;
        end
        deferred = (q.size() != 0);
        e_exc = 1'b0;
        if (!deferred) begin
            if (load_out) begin
                if (bus.dbus_err_i) begin
                    e_exc = 1'b1;
                    load_out = 1'b0;
                end else if (bus.dbus_ack_i) begin
                    q.push_back('{m_rfd, extract(bus.dbus_dat_i, m_size, m_signed, m_adr)});
                    load_out = 1'b0;
                end
            end else if (bus.lsu_load_start_i) begin
                load_out = 1'b1;
                m_rfd = bus.lsu_rfd_i; m_size = bus.lsu_size_i;
                m_signed = bus.lsu_signed_i; m_adr = bus.lsu_adr_lo_i;
            end
            if (bus.alu_valid_i) q.push_back('{bus.alu_rfd_i, bus.alu_result_i});
        end
        e_we = 1'b0;
        if (q.size() != 0) begin
            w = q.pop_front();
            if (!guard || w.adr != 5'd0) begin
                e_we = 1'b1; e_adr = w.adr; e_dat = w.dat;
            end
        end
        e_stall = load_out || (q.size() != 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("rf_we_o", 32'(bus.rf_we_o), 32'(e_we));
        chk("rfd_adr_o", 32'(bus.rfd_adr_o), 32'(e_adr));
        chk("result_o", bus.result_o, e_dat);
        chk("stall_o", 32'(bus.stall_o), 32'(e_stall));
        chk("except_o", 32'(bus.except_o), 32'(e_exc));
    endtask

    // Inputs change just after the falling edge; model and checks follow each rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clr();
        rst = 1'b0;
        bus.alu_valid_i = 1'b0; bus.alu_rfd_i = '0; bus.alu_result_i = '0;
        bus.lsu_load_start_i = 1'b0; bus.lsu_rfd_i = '0; bus.lsu_size_i = '0;
        bus.lsu_signed_i = 1'b0; bus.lsu_adr_lo_i = '0;
        bus.dbus_ack_i = 1'b0; bus.dbus_err_i = 1'b0; bus.dbus_dat_i = '0;
    endtask

    task automatic start_load(input logic [4:0] rfd, input logic [1:0] sz, input bit sg, input logic [1:0] a);
        bus.lsu_load_start_i = 1'b1; bus.lsu_rfd_i = rfd; bus.lsu_size_i = sz;
        bus.lsu_signed_i = sg; bus.lsu_adr_lo_i = a;
        tick();
        bus.lsu_load_start_i = 1'b0;
    endtask

    task automatic ack_load(input logic [31:0] d);
        bus.dbus_ack_i = 1'b1; bus.dbus_dat_i = d;
        tick();
        bus.dbus_ack_i = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_we", 32'(bus.rf_we_o), 32'd0);
        chk("reset_result", bus.result_o, 32'd0);
        chk("reset_stall", 32'(bus.stall_o), 32'd0);
        rst = 1'b0;
        tick();

        bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd3; bus.alu_result_i = 32'h12345678;
        tick();
        bus.alu_valid_i = 1'b0;
        chk("alu_we", 32'(bus.rf_we_o), 32'd1);
        chk("alu_adr", 32'(bus.rfd_adr_o), 32'd3);
        chk("alu_result", bus.result_o, 32'h12345678);
        chk("alu_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("alu_we_one_cycle", 32'(bus.rf_we_o), 32'd0);
        chk("alu_result_held", bus.result_o, 32'h12345678);

        start_load(5'd7, 2'b00, 1'b1, 2'd2);
        chk("sb_stall_start", 32'(bus.stall_o), 32'd1);
        tick();
        tick();
        chk("sb_stall_wait", 32'(bus.stall_o), 32'd1);
        ack_load(32'h11228044);
        chk("sb_we", 32'(bus.rf_we_o), 32'd1);
        chk("sb_adr", 32'(bus.rfd_adr_o), 32'd7);
        chk("sb_result", bus.result_o, 32'hFFFFFF80);
        chk("sb_model", e_dat, 32'hFFFFFF80);
        chk("sb_stall_drop", 32'(bus.stall_o), 32'd0);

        start_load(5'd9, 2'b01, 1'b0, 2'd2);
        ack_load(32'hAAAA8001);
        chk("uh_result", bus.result_o, 32'h00008001);
        chk("uh_model", e_dat, 32'h00008001);
        start_load(5'd9, 2'b01, 1'b1, 2'd2);
        ack_load(32'hAAAA8001);
        chk("sh_result", bus.result_o, 32'hFFFF8001);

        start_load(5'd5, 2'b10, 1'b0, 2'd0);
        bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd6; bus.alu_result_i = 32'h1;
        ack_load(32'hDEADBEEF);
        bus.alu_valid_i = 1'b0;
        chk("col_load_adr", 32'(bus.rfd_adr_o), 32'd5);
        chk("col_load_result", bus.result_o, 32'hDEADBEEF);
        chk("col_stall", 32'(bus.stall_o), 32'd1);
        tick();
        chk("col_alu_we", 32'(bus.rf_we_o), 32'd1);
        chk("col_alu_adr", 32'(bus.rfd_adr_o), 32'd6);
        chk("col_alu_result", bus.result_o, 32'h1);
        chk("col_model", e_dat, 32'h1);
        chk("col_stall_drop", 32'(bus.stall_o), 32'd0);

        start_load(5'd4, 2'b10, 1'b0, 2'd0);
        bus.dbus_err_i = 1'b1;
        tick();
        bus.dbus_err_i = 1'b0;
        chk("err_we", 32'(bus.rf_we_o), 32'd0);
        chk("err_except", 32'(bus.except_o), 32'd1);
        chk("err_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("err_except_pulse", 32'(bus.except_o), 32'd0);

        start_load(5'd8, 2'b10, 1'b0, 2'd0);
        rst = 1'b1;
        bus.dbus_ack_i = 1'b1; bus.dbus_dat_i = 32'hCAFEF00D;
        tick();
        clr();
        chk("rst_mid_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst_mid_result", bus.result_o, 32'd0);
        chk("rst_mid_adr", 32'(bus.rfd_adr_o), 32'd0);
        tick();
        chk("rst_mid_no_write", 32'(bus.rf_we_o), 32'd0);

        bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd0; bus.alu_result_i = 32'h55;
        tick();
        bus.alu_valid_i = 1'b0;
`ifdef MOR1KX_WB_R0_GUARD_EN
        chk("r0_guard_we", 32'(bus.rf_we_o), 32'd0);
`else
        chk("r0_pass_we", 32'(bus.rf_we_o), 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            bus.alu_valid_i      = ($urandom_range(0, 1) == 1);
            bus.alu_rfd_i        = 5'($urandom);
            bus.alu_result_i     = $urandom;
            bus.lsu_load_start_i = ($urandom_range(0, 99) < 30);
            bus.lsu_rfd_i        = 5'($urandom);
            bus.lsu_size_i       = 2'($urandom);
            bus.lsu_signed_i     = 1'($urandom);
            bus.lsu_adr_lo_i     = 2'($urandom);
            bus.dbus_ack_i       = ($urandom_range(0, 99) < 25);
            bus.dbus_err_i       = ($urandom_range(0, 99) < 5);
            bus.dbus_dat_i       = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
